// File: rtl/data_memory_unit.sv
// Multi-cycle 2**ADDR_W x 16 data memory with a req/busy/done handshake and programmable wait states.
// Optional DMEM_MMIO_EN: the all-ones address maps to a 16-bit output register io_out instead of RAM.
module data_memory_unit #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] word_a,
  input  logic [15:0]       word_w,
  output logic [15:0]       word_r,
  output logic              busy,
  output logic              done
`ifdef DMEM_MMIO_EN
  ,
  output logic [15:0]       io_out
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t            state;
  logic [2:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_a;
  logic [15:0]       lat_w;
  logic [15:0]       ram [2**ADDR_W];

  logic commit;
  logic is_io;
  logic [15:0] rd_data;

  assign commit = (state == ACCESS) && (cnt == 3'd0);

`ifdef DMEM_MMIO_EN
  assign is_io   = (lat_a == '1);
  assign rd_data = is_io ? io_out : ram[lat_a];
`else
  assign is_io   = 1'b0;
  assign rd_data = ram[lat_a];
`endif

  // NOTE: the RAM array has no reset; clearing 2**ADDR_W words would need a
  // sequencer, and software never relies on power-up contents.
  always_ff @(posedge clock) begin
    if (!reset && commit && lat_we && !is_io)
      ram[lat_a] <= lat_w;
  end

  // NOTE: every sequential assignment uses <= so all registers update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      word_r <= 16'h0000;
      lat_we <= 1'b0;
      lat_a  <= '0;
      lat_w  <= 16'h0000;
`ifdef DMEM_MMIO_EN
      io_out <= 16'h0000;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (req) begin
            lat_we <= we;
            lat_a  <= word_a;
            lat_w  <= word_w;
            cnt    <= WAIT_INIT;
            busy   <= 1'b1;
            state  <= ACCESS;
          end else begin
            state  <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            // Stores leave word_r untouched so the last load stays visible.
            if (!lat_we)
              word_r <= rd_data;
`ifdef DMEM_MMIO_EN
            if (lat_we && is_io)
              io_out <= lat_w;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench for data_memory_unit: directed handshake/reset/MMIO steps plus
// randomized loads and stores checked against an associative-array memory model.
module tb_data_memory_unit;

  localparam int W  = 1;
  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          req;
  logic          we;
  logic [AW-1:0] word_a;
  logic [15:0]   word_w;
  logic [15:0]   word_r;
  logic          busy;
  logic          done;
`ifdef DMEM_MMIO_EN
  logic [15:0]   io_out;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: only addresses that were stored are ever loaded back.
  logic [15:0]   mem_model [int];
  logic [AW-1:0] written [$];
  logic [15:0]   last_load = 16'h0000;
  logic [15:0]   io_model  = 16'h0000;

  always #5 clock = ~clock;

  data_memory_unit #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .word_a (word_a),
    .word_w (word_w),
    .word_r (word_r),
    .busy   (busy),
    .done   (done)
`ifdef DMEM_MMIO_EN
    ,
    .io_out (io_out)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_io(input logic [AW-1:0] a);
`ifdef DMEM_MMIO_EN
    return a == '1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_busy", {15'b0, busy}, 16'h0000);
      check("idle_done", {15'b0, done}, 16'h0000);
      check("idle_word_r", word_r, last_load);
    end
  endtask

  // Starts at a negedge (IDLE or DONE cycle) and returns at the negedge of the
  // DONE cycle with req low; inputs are scrambled while the access is in flight.
  task automatic access(input logic st, input logic [AW-1:0] a, input logic [15:0] d,
                        input logic poke);
    req = 1'b1; we = st; word_a = a; word_w = d;
    step();
    we = ~st; word_a = AW'($urandom); word_w = 16'($urandom); req = poke;
    for (int k = 0; k <= W; k++) begin
      check("acc_busy", {15'b0, busy}, 16'h0001);
      check("acc_done_early", {15'b0, done}, 16'h0000);
      step();
    end
    if (st) begin
      if (is_io(a)) io_model = d;
      else          mem_model[int'(a)] = d;
      written.push_back(a);
    end else begin
      last_load = is_io(a) ? io_model : mem_model[int'(a)];
    end
    req = 1'b0; we = 1'b0;
    check("done_pulse", {15'b0, done}, 16'h0001);
    check("done_busy", {15'b0, busy}, 16'h0000);
    check("done_word_r", word_r, last_load);
`ifdef DMEM_MMIO_EN
    check("io_out", io_out, io_model);
`endif
  endtask

  initial begin
    logic          st;
    logic [AW-1:0] a;
    logic [15:0]   d;

    reset = 1'b1; req = 1'b0; we = 1'b0; word_a = '0; word_w = 16'h0000;
    step();
    step();
    reset = 1'b0;
    idle(5);

    // Store then load, with an ignored req pulse and scrambled inputs mid-access.
    access(1'b1, 10'h012, 16'hBEEF, 1'b1);
    idle(1);
    access(1'b0, 10'h012, 16'h0000, 1'b0);
    idle(3);

    // Back-to-back with req held high: store then load at 0x3FE.
    access(1'b1, 10'h3FE, 16'h1234, 1'b1);
    access(1'b0, 10'h3FE, 16'h0000, 1'b1);
    idle(2);

    // Reset one cycle into a store: the store must not commit.
    access(1'b1, 10'h005, 16'h0000, 1'b0);
    idle(1);
    req = 1'b1; we = 1'b1; word_a = 10'h005; word_w = 16'hAAAA;
    step();
    req = 1'b0;
    check("rst_pre_busy", {15'b0, busy}, 16'h0001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    last_load = 16'h0000;
    io_model  = 16'h0000;
    check("rst_busy", {15'b0, busy}, 16'h0000);
    check("rst_done", {15'b0, done}, 16'h0000);
    check("rst_word_r", word_r, 16'h0000);
    idle(3);
    access(1'b0, 10'h005, 16'h0000, 1'b0);
    idle(1);

    // All-ones address: I/O register with DMEM_MMIO_EN, plain RAM otherwise.
    access(1'b1, 10'h3FF, 16'h00C3, 1'b0);
    idle(1);
    access(1'b0, 10'h3FF, 16'h0000, 1'b0);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      st = (written.size() == 0) || ($urandom_range(0, 1) == 1);
      if (st) begin
        case ($urandom_range(0, 3))
          0:       a = '1;
          1:       a = '0;
          default: a = AW'($urandom);
        endcase
      end else begin
        a = written[$urandom_range(0, written.size() - 1)];
      end
      d = 16'($urandom);
      access(st, a, d, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 2));
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
